cpu_boot_sequencer: RTL and testbench

Sequences the single-cycle `computer` from power-up through program load, CPU reset, a bounded run and result capture. It streams program words from a ready/valid loader port into instruction-memory write lines while holding the CPU in reset. It then releases reset after a fixed hold and gates the CPU clock-enable for a programmable cycle budget. When the budget ends it latches the CPU's 8-bit outputPort as the run result. It sits between the board-level loader/host logic and the `computer` top.

---
 rtl/boot_seq_pkg.sv | 21 ++
 rtl/boot_run_timer.sv | 46 ++++
 rtl/cpu_boot_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_boot_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// rtl/boot_seq_pkg.sv - shared state encoding and default widths for the boot sequencer
//
// Purpose : state enum and default parameter values used by cpu_boot_sequencer
//           and boot_run_timer.
// Ports   : none (package).
package boot_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RESET = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int INSTR_W_DEF    = 16;
   localparam int ADDR_W_DEF     = 8;
   localparam int RST_CYCLES_DEF = 2;
   localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/boot_run_timer.sv
// rtl/boot_run_timer.sv - saturating CPU cycle counter with run-budget compare
//
// Purpose : counts enabled CPU cycles during RUN and flags the last budgeted cycle.
// Ports   : clk, rst         - clock, async active-high reset
//           i_clear          - latch i_limit and zero the counter (entering RUN)
//           i_run            - CPU enabled this cycle; count it
//           i_limit          - run budget, 0 = unlimited
//           o_cycle_count    - cycles executed so far (saturating)
//           o_limit_hit      - this is the final budgeted cycle
module boot_run_timer
   import boot_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_run,
   input  logic [CNT_W-1:0] i_limit,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic             o_limit_hit
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_limit <= '0;
      end else if (i_clear) begin
         r_count <= '0;
         r_limit <= i_limit;
      end else if (i_run && (r_count != '1)) begin
         r_count <= r_count + ONE;
      end
   end

   // Hit on the cycle whose count is limit-1, so the edge that leaves RUN
   // completes exactly `limit` enabled cycles.
   assign o_limit_hit   = i_run && (r_limit != '0) && (r_count == (r_limit - ONE));
   assign o_cycle_count = r_count;

endmodule

// File: rtl/cpu_boot_sequencer.sv
// rtl/cpu_boot_sequencer.sv - program load, CPU reset, bounded run and result capture
//
// Purpose : streams loader words into instruction memory with the CPU held in
//           reset, releases reset after RST_CYCLES, runs the CPU for a budget
//           and captures its output port.
// Ports   : clk, rst                 - clock, async active-high reset
//           i_start, i_abort         - sequence control pulses
//           i_run_limit              - run budget (0 = unlimited), sampled leaving RESET
//           i_load_valid/last/data   - loader stream; o_load_ready accepts
//           o_imem_we/addr/wdata     - instruction memory write port
//           o_cpu_rst, o_cpu_en      - CPU reset and clock-enable
//           i_cpu_out, o_result      - CPU output port and captured result
//           o_load_count             - words written by the last load
//           o_cycle_count            - CPU cycles of the current/last run
//           o_busy, o_done           - status
module cpu_boot_sequencer
   import boot_seq_pkg::*;
#(
   parameter int INSTR_W    = INSTR_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int RST_CYCLES = RST_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [CNT_W-1:0]   i_run_limit,
   input  logic               i_load_valid,
   input  logic               i_load_last,
   input  logic [INSTR_W-1:0] i_load_data,
   output logic               o_load_ready,
   output logic               o_imem_we,
   output logic [ADDR_W-1:0]  o_imem_addr,
   output logic [INSTR_W-1:0] o_imem_wdata,
   output logic               o_cpu_rst,
   output logic               o_cpu_en,
   input  logic [7:0]         i_cpu_out,
   output logic [7:0]         o_result,
   output logic [ADDR_W:0]    o_load_count,
   output logic [CNT_W-1:0]   o_cycle_count,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic [3:0]        RST_INIT = 4'(RST_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_load_count;
   logic [3:0]        r_rst_cnt;
   logic [7:0]        r_result;
   logic              r_cpu_rst;
   logic              r_cpu_en;
   logic              r_busy;
   logic              r_done;

   logic w_hs;
   logic w_start_load;
   logic w_load_exit;
   logic w_run_enter;
   logic w_run_exit;
   logic w_limit_hit;

   always_comb begin
      w_next       = r_state;
      w_hs         = 1'b0;
      w_start_load = 1'b0;
      w_load_exit  = 1'b0;
      w_run_enter  = 1'b0;
      w_run_exit   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            // start beats abort here; abort alone is ignored in DONE
            if (i_start) begin
               w_next       = ST_LOAD;
               w_start_load = 1'b1;
            end
         end
         ST_LOAD: begin
            if (i_abort) begin
               w_next = ST_IDLE;
            end else if (i_load_valid) begin
               w_hs = 1'b1;
               if (i_load_last || (r_addr == ADDR_MAX)) begin
                  w_next      = ST_RESET;
                  w_load_exit = 1'b1;
               end
            end
         end
         ST_RESET: begin
            if (r_rst_cnt == 4'd0) begin
               w_next      = ST_RUN;
               w_run_enter = 1'b1;
            end
         end
         ST_RUN: begin
            if (i_abort || w_limit_hit) begin
               w_next     = ST_DONE;
               w_run_exit = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_load_count <= '0;
         r_rst_cnt    <= '0;
         r_result     <= '0;
         r_cpu_rst    <= 1'b1;
         r_cpu_en     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state   <= w_next;
         // Status outputs are registered from the next state so they line up
         // with the state register without a decode stage on the outputs.
         r_cpu_rst <= !((w_next == ST_RUN) || (w_next == ST_DONE));
         r_cpu_en  <= (w_next == ST_RUN);
         r_busy    <= (w_next == ST_LOAD) || (w_next == ST_RESET) || (w_next == ST_RUN);
         r_done    <= (w_next == ST_DONE);

         if (w_start_load) begin
            r_addr       <= '0;
            r_load_count <= '0;
         end else if (w_hs) begin
            r_load_count <= r_load_count + 1'b1;
            // Hold at the top address so a full load never wraps to 0.
            if (r_addr != ADDR_MAX) begin
               r_addr <= r_addr + 1'b1;
            end
         end

         if (w_load_exit) begin
            r_rst_cnt <= RST_INIT;
         end else if ((r_state == ST_RESET) && (r_rst_cnt != 4'd0)) begin
            r_rst_cnt <= r_rst_cnt - 4'd1;
         end

         if (w_run_exit) begin
            r_result <= i_cpu_out;
         end
      end
   end

   boot_run_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (w_run_enter),
      .i_run         (r_state == ST_RUN),
      .i_limit       (i_run_limit),
      .o_cycle_count (o_cycle_count),
      .o_limit_hit   (w_limit_hit)
   );

   assign o_load_ready = (r_state == ST_LOAD);
   assign o_imem_we    = w_hs;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = i_load_data;
   assign o_cpu_rst    = r_cpu_rst;
   assign o_cpu_en     = r_cpu_en;
   assign o_result     = r_result;
   assign o_load_count = r_load_count;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb/tb_cpu_boot_sequencer.sv - directed self-checking bench for cpu_boot_sequencer
module tb_cpu_boot_sequencer;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 3;
   localparam int CNT_W   = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               start, abort, load_valid, load_last;
   logic [CNT_W-1:0]   run_limit;
   logic [INSTR_W-1:0] load_data;
   logic [7:0]         cpu_out;
   logic               load_ready, imem_we, cpu_rst, cpu_en, busy, done;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic [7:0]         result;
   logic [ADDR_W:0]    load_count;
   logic [CNT_W-1:0]   cycle_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cpu_boot_sequencer #(
      .INSTR_W    (INSTR_W),
      .ADDR_W     (ADDR_W),
      .RST_CYCLES (2),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (start),
      .i_abort       (abort),
      .i_run_limit   (run_limit),
      .i_load_valid  (load_valid),
      .i_load_last   (load_last),
      .i_load_data   (load_data),
      .o_load_ready  (load_ready),
      .o_imem_we     (imem_we),
      .o_imem_addr   (imem_addr),
      .o_imem_wdata  (imem_wdata),
      .o_cpu_rst     (cpu_rst),
      .o_cpu_en      (cpu_en),
      .i_cpu_out     (cpu_out),
      .o_result      (result),
      .o_load_count  (load_count),
      .o_cycle_count (cycle_count),
      .o_busy        (busy),
      .o_done        (done)
   );

   typedef struct {
      logic        start, abort, valid, last;
      logic [15:0] data;
      logic        ready, we;
      logic [2:0]  addr;
      logic        cpu_rst, en, busy, done;
      logic [3:0]  lc;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic s, a, v, l, input logic [15:0] d,
                               input logic rdy, we, input logic [2:0] ad,
                               input logic cr, en, bs, dn, input logic [3:0] lc);
      vec_t t;
      t.start = s; t.abort = a; t.valid = v; t.last = l; t.data = d;
      t.ready = rdy; t.we = we; t.addr = ad;
      t.cpu_rst = cr; t.en = en; t.busy = bs; t.done = dn; t.lc = lc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, a, v, l, input logic [15:0] d);
      start = s; abort = a; load_valid = v; load_last = l; load_data = d;
   endtask

   task automatic to_sample;
      @(negedge clk);
   endtask

   task automatic to_drive;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // load 3 words with a gap, RESET for 2 cycles, then a 5-cycle run
      vecs[0]  = mk(1,0,0,0,16'h0000, 0,0,0, 1,0,0,0, 0);
      vecs[1]  = mk(0,0,1,0,16'h1111, 1,1,0, 1,0,1,0, 0);
      vecs[2]  = mk(0,0,1,0,16'h2222, 1,1,1, 1,0,1,0, 1);
      vecs[3]  = mk(0,0,0,0,16'hDEAD, 1,0,2, 1,0,1,0, 2);
      vecs[4]  = mk(0,0,1,1,16'h3333, 1,1,2, 1,0,1,0, 2);
      vecs[5]  = mk(0,0,1,0,16'h4444, 0,0,3, 1,0,1,0, 3);
      vecs[6]  = mk(0,0,0,0,16'h0000, 0,0,3, 1,0,1,0, 3);
      vecs[7]  = mk(0,0,0,0,16'h0000, 0,0,3, 0,1,1,0, 3);
      vecs[8]  = mk(1,0,0,0,16'h0000, 0,0,3, 0,1,1,0, 3);
      vecs[9]  = mk(0,0,0,0,16'h0000, 0,0,3, 0,1,1,0, 3);
      vecs[10] = mk(0,0,0,0,16'h0000, 0,0,3, 0,1,1,0, 3);
      vecs[11] = mk(0,0,0,0,16'h0000, 0,0,3, 0,1,1,0, 3);
      vecs[12] = mk(0,0,0,0,16'h0000, 0,0,3, 0,0,0,1, 3);

      rst = 1'b1;
      drive(0, 0, 0, 0, 16'h0);
      run_limit = 16'd5;
      cpu_out   = 8'h0F;

      #40;
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_ready", load_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 8'h00);
      chk("rst_load_count", load_count, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_addr", imem_addr, 0);
      #12;
      rst = 1'b0;
      to_drive();

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].start, vecs[i].abort, vecs[i].valid, vecs[i].last, vecs[i].data);
         to_sample();
         chk($sformatf("v%0d_ready", i), load_ready, vecs[i].ready);
         chk($sformatf("v%0d_we", i), imem_we, vecs[i].we);
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
         if (vecs[i].we)
            chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].data);
         chk($sformatf("v%0d_cpu_rst", i), cpu_rst, vecs[i].cpu_rst);
         chk($sformatf("v%0d_cpu_en", i), cpu_en, vecs[i].en);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
         chk($sformatf("v%0d_done", i), done, vecs[i].done);
         chk($sformatf("v%0d_load_count", i), load_count, vecs[i].lc);
         to_drive();
      end
      chk("run5_result", result, 8'h0F);
      chk("run5_cycle_count", cycle_count, 16'd5);

      // start+abort together in DONE: start wins, reload begins
      drive(1, 1, 0, 0, 16'h0);
      to_drive();
      drive(0, 0, 1, 0, 16'hAAAA);
      to_sample();
      chk("reload_ready", load_ready, 1);
      chk("reload_addr", imem_addr, 0);
      chk("reload_lc", load_count, 0);
      chk("reload_we", imem_we, 1);
      to_drive();
      drive(0, 1, 1, 0, 16'hBBBB);
      to_sample();
      chk("abort_cycle_we", imem_we, 0);
      to_drive();
      drive(0, 0, 1, 0, 16'hCCCC);
      to_sample();
      chk("abort_idle_ready", load_ready, 0);
      chk("abort_idle_we", imem_we, 0);
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_cpu_rst", cpu_rst, 1);
      chk("abort_idle_lc", load_count, 1);
      to_drive();

      // full memory: 8 words, load_last never set
      run_limit = 16'd0;
      cpu_out   = 8'hA5;
      drive(1, 0, 0, 0, 16'h0);
      to_drive();
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, 0, 16'h0100 + 16'(i));
         to_sample();
         chk($sformatf("full%0d_we", i), imem_we, 1);
         chk($sformatf("full%0d_addr", i), imem_addr, i);
         chk($sformatf("full%0d_wdata", i), imem_wdata, 16'h0100 + 16'(i));
         to_drive();
      end
      drive(0, 0, 1, 0, 16'h0999);
      to_sample();
      chk("full_nowrap_we", imem_we, 0);
      chk("full_ready", load_ready, 0);
      chk("full_lc", load_count, 8);
      chk("full_cpu_rst", cpu_rst, 1);
      chk("full_busy", busy, 1);
      to_drive();
      drive(0, 0, 0, 0, 16'h0);
      to_drive();

      // unlimited run, abort on the 20th enabled cycle
      for (int k = 1; k <= 20; k++) begin
         drive(0, (k == 20), 0, 0, 16'h0);
         to_sample();
         chk($sformatf("unl%0d_cpu_en", k), cpu_en, 1);
         to_drive();
      end
      drive(0, 0, 0, 0, 16'h0);
      to_sample();
      chk("unl_done", done, 1);
      chk("unl_cpu_en", cpu_en, 0);
      chk("unl_cpu_rst", cpu_rst, 0);
      chk("unl_cycle_count", cycle_count, 16'd20);
      chk("unl_result", result, 8'hA5);
      to_drive();

      drive(0, 1, 0, 0, 16'h0);
      to_drive();
      drive(0, 0, 0, 0, 16'h0);
      to_sample();
      chk("done_abort_ignored", done, 1);
      chk("done_hold_cycles", cycle_count, 16'd20);
      to_drive();

      drive(1, 0, 0, 0, 16'h0);
      to_drive();
      drive(0, 0, 0, 0, 16'h0);
      to_sample();
      chk("reload2_ready", load_ready, 1);
      chk("reload2_addr", imem_addr, 0);
      chk("reload2_lc", load_count, 0);
      chk("reload2_done", done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
